writeback_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback result (RegWrite/rd/Value);
  - a long-latency execution unit (multiply/divide) that returns results out of band.
- Buffers long-latency results in a small FIFO and keeps a pending-destination scoreboard for issue-stage hazard stalls.
- Includes a starvation counter that stalls pipeline writeback so buffered results drain.
- Sits between the writeback stage and the register file.

---
 rtl/writeback_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_writeback_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a FIFO-buffered
// long-latency unit. Define WBARB_BYPASS_EN for same-cycle writes of long-unit results on an idle port.
module writeback_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_WbRegWrite,
  input  logic [4:0]  i_WbRd,
  input  logic [31:0] i_WbValue,
  output logic        o_StallWb,
  input  logic        i_LuValid,
  input  logic [4:0]  i_LuRd,
  input  logic [31:0] i_LuValue,
  output logic        o_LuReady,
  input  logic        i_IssueValid,
  input  logic [4:0]  i_IssueRd,
  output logic [31:0] o_PendingMask,
  output logic        o_RegWrite,
  output logic [4:0]  o_Rd,
  output logic [31:0] o_Value
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = 8;

  logic [4:0]      rdMem  [DEPTH];
  logic [31:0]     valMem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] count;
  logic [PtrW-1:0] countNext;
  logic            fullQ;
  logic            fifoEmpty;
  logic [4:0]      headRd;
  logic [31:0]     headValue;

  logic [CntW-1:0] starveCnt;
  logic [CntW-1:0] starveNext;
  logic            stallQ;
  logic            stallNext;
  logic [31:0]     pendingQ;
  logic [31:0]     pendingNext;

  logic            wbEff;
  logic            luAccept;
  logic            doPush;
  logic            doPop;
  logic            headLoses;
  logic            bypassHit;
  logic            regWriteC;
  logic [4:0]      rdC;
  logic [31:0]     valueC;

  assign count     = wrPtr - rdPtr;
  assign fifoEmpty = (count == '0);
  assign headRd    = rdMem[rdPtr[AddrW-1:0]];
  assign headValue = valMem[rdPtr[AddrW-1:0]];

  assign wbEff     = i_WbRegWrite && (i_WbRd != 5'd0);
  assign o_LuReady = i_Reset_n & ~fullQ;
  assign luAccept  = i_LuValid && o_LuReady;

`ifdef WBARB_BYPASS_EN
  // Idle port and empty FIFO: the long-unit result skips the buffer entirely.
  assign bypassHit = luAccept && (i_LuRd != 5'd0) && fifoEmpty && !wbEff;
`else
  assign bypassHit = 1'b0;
`endif

  assign doPush = luAccept && (i_LuRd != 5'd0) && !bypassHit;

  // Write-port arbitration; a stalled pipeline never writes.
  always_comb begin
    regWriteC = 1'b0;
    rdC       = i_WbRd;
    valueC    = i_WbValue;
    doPop     = 1'b0;
    headLoses = 1'b0;
    if (stallQ) begin
      doPop = !fifoEmpty;
    end else if (wbEff) begin
      regWriteC = 1'b1;
      headLoses = !fifoEmpty;
    end else begin
      doPop = !fifoEmpty;
    end
    if (doPop) begin
      regWriteC = 1'b1;
      rdC       = headRd;
      valueC    = headValue;
    end else if (bypassHit) begin
      regWriteC = 1'b1;
      rdC       = i_LuRd;
      valueC    = i_LuValue;
    end
  end

  assign countNext = count + PtrW'(doPush) - PtrW'(doPop);

  // Starvation tracking: stall latches once the head has lost too often, releases after drain.
  always_comb begin
    starveNext = starveCnt;
    if (doPop || fifoEmpty) begin
      starveNext = '0;
    end else if (headLoses && (starveCnt != '1)) begin
      starveNext = starveCnt + CntW'(1);
    end
    if (stallQ) begin
      stallNext = !fifoEmpty;
    end else begin
      stallNext = (starveNext >= CntW'(STARVE_LIMIT));
    end
  end

  // Pending scoreboard; a same-cycle issue to the retiring register keeps the bit set.
  always_comb begin
    pendingNext = pendingQ;
    if (doPop || bypassHit) begin
      pendingNext[rdC] = 1'b0;
    end
    if (i_IssueValid) begin
      pendingNext[i_IssueRd] = 1'b1;
    end
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fullQ     <= 1'b0;
      starveCnt <= '0;
      stallQ    <= 1'b0;
      pendingQ  <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      fullQ     <= (countNext == PtrW'(DEPTH));
      starveCnt <= starveNext;
      stallQ    <= stallNext;
      pendingQ  <= pendingNext;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (doPush) begin
      rdMem[wrPtr[AddrW-1:0]]  <= i_LuRd;
      valMem[wrPtr[AddrW-1:0]] <= i_LuValue;
    end
  end

  assign o_RegWrite    = regWriteC & i_Reset_n;
  assign o_Rd          = rdC;
  assign o_Value       = valueC;
  assign o_StallWb     = stallQ;
  assign o_PendingMask = pendingQ;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Bench for writeback_port_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_writeback_port_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbValue;
  logic        stallWb;
  logic        luValid;
  logic [4:0]  luRd;
  logic [31:0] luValue;
  logic        luReady;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic [31:0] pendingMask;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] value;

  always #5 clk = ~clk;

  writeback_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rstN),
    .i_WbRegWrite (wbRegWrite),
    .i_WbRd       (wbRd),
    .i_WbValue    (wbValue),
    .o_StallWb    (stallWb),
    .i_LuValid    (luValid),
    .i_LuRd       (luRd),
    .i_LuValue    (luValue),
    .o_LuReady    (luReady),
    .i_IssueValid (issueValid),
    .i_IssueRd    (issueRd),
    .o_PendingMask(pendingMask),
    .o_RegWrite   (regWrite),
    .o_Rd         (rd),
    .o_Value      (value)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: buffered results in arrival order.
  logic [36:0] mQ[$];
  int          mStarve = 0;
  bit          mStall  = 1'b0;
  logic [31:0] mMask   = '0;

  bit          obsRegWrite;
  bit          obsStall;
  bit          obsReady;
  logic [4:0]  obsRd;
  logic [31:0] obsValue;
  logic [31:0] obsMask;
  logic [36:0] obsWrites[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic setIdle();
    wbRegWrite = 1'b0; wbRd = '0; wbValue = '0;
    luValid = 1'b0; luRd = '0; luValue = '0;
    issueValid = 1'b0; issueRd = '0;
  endtask

  task automatic modelReset();
    mQ.delete();
    mStarve = 0;
    mStall  = 1'b0;
    mMask   = '0;
  endtask

  // One clock: inputs already driven; check at negedge, advance model, return at posedge+1.
  task automatic step();
    bit          wbEff, empty, ready, doPop, lose, byp, expWr;
    logic [4:0]  expRd;
    logic [31:0] expVal;
    logic [36:0] head;
    @(negedge clk);
    obsRegWrite = regWrite; obsRd = rd; obsValue = value;
    obsStall = stallWb; obsReady = luReady; obsMask = pendingMask;
    if (regWrite && value[31:16] == 16'hF0F0) obsWrites.push_back({rd, value});

    wbEff = wbRegWrite && (wbRd != 5'd0);
    empty = (mQ.size() == 0);
    ready = (mQ.size() < DEPTH);
    head  = empty ? 37'd0 : mQ[0];
    doPop = 1'b0; lose = 1'b0; byp = 1'b0; expWr = 1'b0;
    expRd = wbRd; expVal = wbValue;
    if (mStall) doPop = !empty;
    else if (wbEff) begin expWr = 1'b1; lose = !empty; end
    else doPop = !empty;
`ifdef WBARB_BYPASS_EN
    byp = empty && !wbEff && luValid && ready && (luRd != 5'd0);
`endif
    if (doPop) begin expWr = 1'b1; expRd = head[36:32]; expVal = head[31:0]; end
    if (byp) begin expWr = 1'b1; expRd = luRd; expVal = luValue; end

    checkVal("regwrite", 32'(regWrite), 32'(expWr));
    checkVal("rd", 32'(rd), 32'(expRd));
    checkVal("value", value, expVal);
    checkVal("stall", 32'(stallWb), 32'(mStall));
    checkVal("ready", 32'(luReady), 32'(ready));
    checkVal("mask", pendingMask, mMask);
    if (issueValid && issueRd != 5'd0) checkVal("issue_legal", 32'(pendingMask[issueRd]), 32'd0);

    if (doPop) mMask[head[36:32]] = 1'b0;
    if (byp) mMask[luRd] = 1'b0;
    if (issueValid) mMask[issueRd] = 1'b1;
    mMask[0] = 1'b0;
    if (doPop || empty) mStarve = 0;
    else if (lose) mStarve++;
    mStall = mStall ? !empty : (mStarve >= int'(STARVE_LIMIT));
    if (doPop) void'(mQ.pop_front());
    if (luValid && ready && (luRd != 5'd0) && !byp) mQ.push_back({luRd, luValue});
    @(posedge clk);
    #1;
  endtask

  task automatic randomPhase(input int cycles);
    logic [4:0]  outstanding[$];
    logic [4:0]  r;
    logic [4:0]  curRd = '0;
    logic [31:0] curVal = '0;
    bit          presenting = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      wbRegWrite = ($urandom_range(0, 99) < 60);
      wbRd       = 5'($urandom_range(0, 31));
      wbValue    = $urandom;
      issueValid = 1'b0;
      issueRd    = '0;
      if ($urandom_range(0, 3) == 0) begin
        r = 5'($urandom_range(1, 31));
        if (!mMask[r]) begin issueValid = 1'b1; issueRd = r; end
      end
      if (!presenting && outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
        presenting = 1'b1; curRd = outstanding.pop_front(); curVal = $urandom;
      end else if (!presenting && $urandom_range(0, 19) == 0) begin
        presenting = 1'b1; curRd = '0; curVal = $urandom;
      end
      luValid = presenting; luRd = curRd; luValue = curVal;
      step();
      if (presenting && obsReady) presenting = 1'b0;
      if (issueValid) outstanding.push_back(issueRd);
    end
  endtask

  initial begin
    int rise, fall, pushed;
    rstN = 1'b0;
    setIdle();
    #2;
    checkVal("reset_regwrite", 32'(regWrite), 32'd0);
    checkVal("reset_stall", 32'(stallWb), 32'd0);
    checkVal("reset_mask", pendingMask, 32'd0);
    checkVal("reset_ready", 32'(luReady), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Pipeline owns the port; x7 retires once the pipeline goes idle.
    issueValid = 1'b1; issueRd = 5'd7;
    step();
    for (int i = 0; i < 4; i++) begin
      setIdle();
      wbRegWrite = 1'b1; wbRd = 5'd5; wbValue = 32'h11;
      luValid = (i == 0); luRd = 5'd7; luValue = 32'h22;
      step();
      checkVal("prio_rd5", 32'(obsRd), 32'd5);
    end
    setIdle();
    step();
    checkVal("x7_rd", 32'(obsRd), 32'd7);
    checkVal("x7_val", obsValue, 32'h22);
    step();
    checkVal("x7_mask_clear", 32'(obsMask[7]), 32'd0);

    // Starvation: stall rises in loss cycle 9, falls the cycle after the FIFO empties.
    setIdle();
    wbRegWrite = 1'b1; wbRd = 5'd5; wbValue = 32'h55;
    luValid = 1'b1; luRd = 5'd10; luValue = 32'hA0;
    step();
    rise = 0; fall = 0;
    for (int idx = 1; idx <= 20; idx++) begin
      luValid = (idx <= 2); luRd = 5'(10 + idx); luValue = 32'(32'hA0 + idx);
      step();
      if (obsStall && rise == 0) rise = idx;
      if (rise != 0 && !obsStall && fall == 0) fall = idx;
    end
    checkVal("stall_rise_cycle", 32'(rise), 32'd9);
    checkVal("stall_fall_cycle", 32'(fall), 32'd13);
    setIdle();
    repeat (3) step();

    // Full and wrap: four pushes with no pops, then six more with the port free.
    for (int i = 0; i < 4; i++) begin
      setIdle();
      wbRegWrite = 1'b1; wbRd = 5'd3; wbValue = 32'h3333;
      luValid = 1'b1; luRd = 5'(i + 1); luValue = 32'hF0F0_0000 | 32'(i);
      step();
    end
    luRd = 5'd5; luValue = 32'hF0F0_0004;
    step();
    checkVal("full_ready_low", 32'(obsReady), 32'd0);
    pushed = 4;
    for (int c = 0; c < 60 && pushed < 10; c++) begin
      setIdle();
      luValid = 1'b1; luRd = 5'(pushed + 1); luValue = 32'hF0F0_0000 | 32'(pushed);
      step();
      if (obsReady) pushed++;
    end
    checkVal("wrap_pushed", 32'(pushed), 32'd10);
    setIdle();
    repeat (12) step();
    checkVal("wrap_count", 32'(obsWrites.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < obsWrites.size()) begin
        checkVal("wrap_rd", 32'(obsWrites[i][36:32]), 32'(i + 1));
        checkVal("wrap_val", obsWrites[i][31:0], 32'hF0F0_0000 | 32'(i));
      end
    end

    // x0 handling on both sources.
    setIdle();
    wbRegWrite = 1'b1; wbRd = 5'd5; wbValue = 32'h5;
    luValid = 1'b1; luRd = 5'd8; luValue = 32'h88;
    step();
    setIdle();
    wbRegWrite = 1'b1; wbRd = 5'd0; wbValue = 32'h99;
    step();
    checkVal("x0_head_we", 32'(obsRegWrite), 32'd1);
    checkVal("x0_head_rd", 32'(obsRd), 32'd8);
    setIdle();
    luValid = 1'b1; luRd = 5'd0; luValue = 32'h77;
    step();
    checkVal("lu_x0_no_write", 32'(obsRegWrite), 32'd0);
    setIdle();
    step();
    checkVal("lu_x0_no_write_late", 32'(obsRegWrite), 32'd0);

    // Long-unit x9 on an idle port.
    issueValid = 1'b1; issueRd = 5'd9;
    step();
    setIdle();
    luValid = 1'b1; luRd = 5'd9; luValue = 32'hDEAD_BEEF;
    step();
`ifdef WBARB_BYPASS_EN
    checkVal("bypass_we", 32'(obsRegWrite), 32'd1);
    checkVal("bypass_rd", 32'(obsRd), 32'd9);
    setIdle();
    step();
    checkVal("bypass_no_late", 32'(obsRegWrite), 32'd0);
`else
    checkVal("lu_same_cycle_we", 32'(obsRegWrite), 32'd0);
    setIdle();
    step();
    checkVal("lu_late_we", 32'(obsRegWrite), 32'd1);
    checkVal("lu_late_rd", 32'(obsRd), 32'd9);
    checkVal("lu_late_val", obsValue, 32'hDEAD_BEEF);
`endif
    setIdle();
    step();

    // Reset with three buffered results and x5..x7 pending.
    for (int i = 5; i <= 7; i++) begin
      setIdle();
      issueValid = 1'b1; issueRd = 5'(i);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      setIdle();
      wbRegWrite = 1'b1; wbRd = 5'd3; wbValue = 32'h3;
      luValid = (i < 3); luRd = 5'(5 + i); luValue = 32'(32'h500 + i);
      step();
    end
    checkVal("pre_reset_mask", obsMask, 32'h0000_00E0);
    #2 rstN = 1'b0;
    #1;
    checkVal("midreset_regwrite", 32'(regWrite), 32'd0);
    checkVal("midreset_mask", pendingMask, 32'd0);
    checkVal("midreset_stall", 32'(stallWb), 32'd0);
    checkVal("midreset_ready", 32'(luReady), 32'd0);
    modelReset();
    setIdle();
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("post_reset_no_write", 32'(obsRegWrite), 32'd0);
    end

    randomPhase(1500);
    setIdle();
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
